// File: rtl/blit_write_buffer.sv
// Write buffer between the blitter byte-merge stage and the memory arbiter.
// Queues merged word writes in a FIFO and drains them over a request/ack handshake.
module blit_write_buffer #(
  parameter int DEPTH     = 8,
  parameter int AF_MARGIN = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [25:0] p6_addr,
  input  logic [31:0] p6_data,
  input  logic [3:0]  p6_byte_enable,
  input  logic        p6_write,
  output logic        almost_full,
  output logic        overflow,
  output logic        busy,
  output logic        mem_request,
  input  logic        mem_ack,
  output logic [25:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_byte_enable
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
  localparam logic [CW-1:0] MARGIN_C = CW'(AF_MARGIN);

  typedef struct packed {
    logic [23:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
  } entry_t;

  entry_t        store [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [CW-1:0] count;
  logic [CW-1:0] next_count;
  logic [CW-1:0] free_next;
  logic          push;
  logic          pop;
  logic          full;
  logic          accept;
  logic          drop;
  logic          unused_addr_lsb;

  // The low address bits never reach memory; the word is always aligned.
  assign unused_addr_lsb = ^p6_addr[1:0];

  always_comb begin
    push       = p6_write && (p6_byte_enable != 4'b0000);
    pop        = mem_request && mem_ack;
    full       = (count == DEPTH_C);
    accept     = push && (!full || pop);
    drop       = push && full && !pop;
    next_count = count;
    if (accept && !pop)
      next_count = count + CW'(1);
    else if (pop && !accept)
      next_count = count - CW'(1);
    free_next  = DEPTH_C - next_count;
  end

  // Control state: counters, pointers and status flags.
  always_ff @(posedge clock) begin
    if (reset) begin
      count       <= '0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      overflow    <= 1'b0;
      almost_full <= 1'b0;
      busy        <= 1'b0;
    end else begin
      count       <= next_count;
      almost_full <= (free_next < MARGIN_C);
      busy        <= (next_count != '0);
      if (accept)
        wr_ptr <= wr_ptr + PW'(1);
      if (pop)
        rd_ptr <= rd_ptr + PW'(1);
      if (drop)
        overflow <= 1'b1;
    end
  end

  // Entry storage carries data only and is never reset.
  always_ff @(posedge clock) begin
    if (accept)
      store[wr_ptr] <= '{addr: p6_addr[25:2], data: p6_data, be: p6_byte_enable};
  end

  assign mem_request     = (count != '0);
  assign mem_addr        = {store[rd_ptr].addr, 2'b00};
  assign mem_wdata       = store[rd_ptr].data;
  assign mem_byte_enable = store[rd_ptr].be;

endmodule

// File: tb/tb_blit_write_buffer.sv
// Directed and randomized bench for blit_write_buffer against a queue-based model.
module tb_blit_write_buffer;

  localparam int DEPTH     = 8;
  localparam int AF_MARGIN = 4;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [25:0] p6_addr = '0;
  logic [31:0] p6_data = '0;
  logic [3:0]  p6_byte_enable = '0;
  logic        p6_write = 1'b0;
  logic        almost_full;
  logic        overflow;
  logic        busy;
  logic        mem_request;
  logic        mem_ack = 1'b0;
  logic [25:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_byte_enable;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct packed {
    logic [25:0] a;
    logic [31:0] d;
    logic [3:0]  be;
  } ent_t;

  ent_t q[$];
  bit   ovf_m = 1'b0;

  blit_write_buffer #(.DEPTH(DEPTH), .AF_MARGIN(AF_MARGIN)) dut (
    .clock(clock), .reset(reset),
    .p6_addr(p6_addr), .p6_data(p6_data), .p6_byte_enable(p6_byte_enable), .p6_write(p6_write),
    .almost_full(almost_full), .overflow(overflow), .busy(busy),
    .mem_request(mem_request), .mem_ack(mem_ack),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_byte_enable(mem_byte_enable)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock, update the model from the inputs that were applied, check outputs.
  task automatic cycle();
    bit   push_m, pop_m;
    ent_t e;
    push_m = p6_write && (p6_byte_enable != 4'b0);
    pop_m  = (q.size() != 0) && mem_ack;
    @(posedge clock);
    if (reset) begin
      q.delete();
      ovf_m = 1'b0;
    end else if (push_m && q.size() == DEPTH && !pop_m) begin
      ovf_m = 1'b1;
    end else begin
      if (pop_m) q.delete(0);
      if (push_m) begin
        e.a  = {p6_addr[25:2], 2'b00};
        e.d  = p6_data;
        e.be = p6_byte_enable;
        q.push_back(e);
      end
    end
    #1;
    chk("mem_request", mem_request, q.size() != 0);
    chk("busy", busy, q.size() != 0);
    chk("almost_full", almost_full, (DEPTH - q.size()) < AF_MARGIN);
    chk("overflow", overflow, ovf_m);
    if (q.size() != 0) begin
      chk("mem_addr", mem_addr, q[0].a);
      chk("mem_wdata", mem_wdata, q[0].d);
      chk("mem_be", mem_byte_enable, q[0].be);
    end
  endtask

  task automatic drive(input logic w, input logic [25:0] a, input logic [31:0] d, input logic [3:0] be);
    p6_write = w;
    p6_addr = a;
    p6_data = d;
    p6_byte_enable = be;
  endtask

  task automatic drain(input int budget);
    int k;
    drive(1'b0, '0, '0, '0);
    mem_ack = 1'b1;
    k = 0;
    while (q.size() != 0 && k < budget) begin
      cycle();
      k++;
    end
    chk("drain_done", q.size() == 0, 1'b1);
    chk("drain_busy", busy, 1'b0);
  endtask

  initial begin
    int pushes, guard;
    // Reset
    reset = 1'b1;
    cycle();
    cycle();
    reset = 1'b0;
    chk("rst_req", mem_request, 1'b0);
    chk("rst_af", almost_full, 1'b0);

    // Single write with ack held high
    mem_ack = 1'b1;
    drive(1'b1, 26'h0001234, 32'hAABBCCDD, 4'b1111);
    cycle();
    chk("single_req", mem_request, 1'b1);
    chk("single_addr", mem_addr, 26'h0001234);
    chk("single_data", mem_wdata, 32'hAABBCCDD);
    drive(1'b0, '0, '0, '0);
    cycle();
    chk("single_busy_low", busy, 1'b0);

    // Back-pressure: five pushes with no ack
    mem_ack = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 26'h100 + 26'(4 * i), $urandom, 4'($urandom_range(1, 15)));
      cycle();
    end
    chk("bp_af", almost_full, 1'b1);
    drive(1'b0, '0, '0, '0);
    cycle();
    cycle();
    chk("bp_head", mem_addr, 26'h100);
    mem_ack = 1'b1;
    cycle();
    chk("bp_af_drop", almost_full, 1'b0);
    drain(20);

    // Overflow: nine pushes with no ack
    mem_ack = 1'b0;
    for (int i = 0; i < 9; i++) begin
      drive(1'b1, 26'h400 + 26'(4 * i), $urandom, 4'hF);
      cycle();
    end
    chk("ovf_set", overflow, 1'b1);
    chk("ovf_count", q.size(), 8);
    drain(20);
    cycle();
    chk("ovf_sticky", overflow, 1'b1);
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    chk("ovf_cleared", overflow, 1'b0);

    // Full with simultaneous pop
    mem_ack = 1'b0;
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 26'h300 + 26'(4 * i), $urandom, 4'hF);
      cycle();
    end
    mem_ack = 1'b1;
    drive(1'b1, 26'h200, 32'h12345678, 4'b0101);
    cycle();
    chk("fullpop_ovf", overflow, 1'b0);
    chk("fullpop_cnt", q.size(), 8);
    drive(1'b0, '0, '0, '0);
    guard = 0;
    while (q.size() > 1 && guard < 20) begin
      cycle();
      guard++;
    end
    chk("fullpop_last", mem_addr, 26'h200);
    drain(5);

    // Zero byte-enable push is discarded
    mem_ack = 1'b0;
    drive(1'b1, 26'h555, 32'hDEADBEEF, 4'b0000);
    cycle();
    chk("be0_noreq", mem_request, 1'b0);

    // Twenty writes with random ack, exercising pointer wrap
    pushes = 0;
    guard = 0;
    while (pushes < 20 && guard < 400) begin
      mem_ack = 1'($urandom);
      if (q.size() < DEPTH - 1 && $urandom_range(0, 2) != 0) begin
        drive(1'b1, 26'($urandom), $urandom, 4'($urandom_range(1, 15)));
        pushes++;
      end else begin
        drive(1'b0, '0, '0, '0);
      end
      cycle();
      guard++;
    end
    chk("stream_pushes", pushes, 20);
    drain(40);

    // Reset mid-transfer with three entries queued
    mem_ack = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 26'h800 + 26'(4 * i), $urandom, 4'hF);
      cycle();
    end
    drive(1'b0, '0, '0, '0);
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    chk("midrst_req", mem_request, 1'b0);
    chk("midrst_busy", busy, 1'b0);
    mem_ack = 1'b1;
    drive(1'b1, 26'h0001234, 32'hAABBCCDD, 4'b1111);
    cycle();
    chk("midrst_addr", mem_addr, 26'h0001234);
    drive(1'b0, '0, '0, '0);
    cycle();
    chk("midrst_done", busy, 1'b0);

    // Randomized soak
    for (int i = 0; i < 400; i++) begin
      mem_ack = ($urandom_range(0, 3) != 0);
      drive(1'($urandom), 26'($urandom), $urandom, 4'($urandom));
      cycle();
    end
    drain(40);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
